pipe_hazard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 38 +++
 rtl/pipe_hazard_ctrl_md_countdown.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline stall/flush scheduler: FSM states, counter width,
// and the per-stage control bundle driven to PC, IF_ID, ID_EX, EX_MEM and MEM_WR.
package hazard_pkg;

    localparam int MD_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN,
        MD_BUSY,
        BR_LOAD
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic mem_wr_bubble;
    } stage_ctrl_t;

    // One control word per resolved priority level, fields in declaration order.
    localparam stage_ctrl_t CTRL_RESET = stage_ctrl_t'(8'b0000_1111);
    localparam stage_ctrl_t CTRL_MEM   = stage_ctrl_t'(8'b0000_0001);
    localparam stage_ctrl_t CTRL_MD    = stage_ctrl_t'(8'b0001_0010);
    localparam stage_ctrl_t CTRL_LOAD  = stage_ctrl_t'(8'b0011_0100);
    localparam stage_ctrl_t CTRL_FLUSH = stage_ctrl_t'(8'b1111_1000);
    localparam stage_ctrl_t CTRL_RUN   = stage_ctrl_t'(8'b1111_0000);

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic uses, input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_countdown.sv
// Occupancy countdown for a multi-cycle mult/div in EX; reports when the count
// has run out so the scheduler can release the stall.
module md_countdown
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [MD_CNT_W-1:0] md_cnt;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt <= '0;
        end else if (load) begin
            md_cnt <= MD_CNT_W'(MD_LATENCY - 2);
        end else if (dec) begin
            md_cnt <= md_cnt - MD_CNT_W'(1);
        end
    end

    assign zero = (md_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Single owner of the 5-stage pipeline advance/hold/flush decision.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_is_branch,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        ex_regwr,
    input  logic        ex_memtoreg,
    input  logic [4:0]  ex_rw,
    input  logic        md_start,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        mem_wr_bubble,
    output logic        md_done,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    state_t      state;
    stage_ctrl_t ctrl;
    logic        md_zero;
    logic        mem_stall;
    logic        src_hit;
    logic        lu_haz;
    logic        br_haz;
    logic        md_stall;
    logic        ld_stall;
    logic        md_load;
    logic        md_dec;

    assign mem_stall = mem_req & ~mem_ready;
    assign src_hit   = reg_match(id_uses_rs, id_rs, ex_rw) | reg_match(id_uses_rt, id_rt, ex_rw);
    assign lu_haz    = ex_regwr & ex_memtoreg & src_hit;
    assign br_haz    = id_is_branch & ex_regwr & src_hit;
    assign md_stall  = ((state == MD_BUSY) && !md_zero) || ((state == RUN) && md_start);
    assign ld_stall  = (state == BR_LOAD) || lu_haz || br_haz;

    // NOTE: the default assignment first keeps this always_comb free of inferred latches.
    always_comb begin
        ctrl = CTRL_RUN;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (mem_stall) begin
            ctrl = CTRL_MEM;
        end else if (md_stall) begin
            ctrl = CTRL_MD;
        end else if (ld_stall) begin
            ctrl = CTRL_LOAD;
        end else if (branch_taken || jump) begin
            ctrl = CTRL_FLUSH;
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign if_id_en      = ctrl.if_id_en;
    assign id_ex_en      = ctrl.id_ex_en;
    assign ex_mem_en     = ctrl.ex_mem_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign mem_wr_bubble = ctrl.mem_wr_bubble;

    // Gated by mem_stall so a held MD_BUSY state cannot pulse md_done twice.
    assign md_done = !rst && !mem_stall && (state == MD_BUSY) && md_zero;

    assign md_load = !mem_stall && (state == RUN) && md_start;
    assign md_dec  = !mem_stall && (state == MD_BUSY) && !md_zero;

    md_countdown #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_countdown (
        .clk  (clk),
        .rst  (rst),
        .load (md_load),
        .dec  (md_dec),
        .zero (md_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else if (!mem_stall) begin
            case (state)
                RUN: begin
                    if (md_start) begin
                        state <= MD_BUSY;
                    end else if (br_haz && ex_memtoreg) begin
                        // Load data reaches the ID compare only from WR: one extra cycle.
                        state <= BR_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (md_zero) begin
                        state <= RUN;
                    end
                end
                BR_LOAD: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!ctrl.pc_en) begin
                stall_q <= stall_q + 32'd1;
            end
            if (ctrl.if_id_flush) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
